// File: rtl/dual_port_ram_be_pkg.sv
// Shared types and helpers for the byte-enabled simple dual-port RAM.
//   rdw_mode_e  : same-address read/write behaviour of the registered read port
//   ram_state_e : clear sequencer states
//   byte_merge  : selects the new or the old byte under one byte-enable bit
package dual_port_ram_be_pkg;

   typedef enum logic {
      RDW_WRITE_FIRST,
      RDW_READ_FIRST
   } rdw_mode_e;

   typedef enum logic {
      ST_CLEAR,
      ST_READY
   } ram_state_e;

   // Per-byte merge; the word-level merge is built by looping over byte lanes,
   // which keeps the helper independent of DATA_WIDTH.
   function automatic logic [7:0] byte_merge(input logic [7:0] old_byte,
                                             input logic [7:0] new_byte,
                                             input logic       be);
      return be ? new_byte : old_byte;
   endfunction

endpackage

// File: rtl/dual_port_ram_be_if.sv
// Request/response bundle of the dual-port RAM.
//   master : requester side (drives write/read requests, receives read data)
//   slave  : RAM side
//   wr_en/wr_addr/wr_data/wr_be : write port, wr_be bit i covers byte i
//   rd_en/rd_addr               : read request
//   rd_data/rd_valid            : read response
//   init_done                   : RAM usable (low while clearing)
interface dual_port_ram_be_if #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned ADDR_WIDTH = 7
);

   logic                    wr_en;
   logic [ADDR_WIDTH-1:0]   wr_addr;
   logic [DATA_WIDTH-1:0]   wr_data;
   logic [DATA_WIDTH/8-1:0] wr_be;
   logic                    rd_en;
   logic [ADDR_WIDTH-1:0]   rd_addr;
   logic [DATA_WIDTH-1:0]   rd_data;
   logic                    rd_valid;
   logic                    init_done;

   modport master (
      output wr_en, wr_addr, wr_data, wr_be, rd_en, rd_addr,
      input  rd_data, rd_valid, init_done
   );

   modport slave (
      input  wr_en, wr_addr, wr_data, wr_be, rd_en, rd_addr,
      output rd_data, rd_valid, init_done
   );

endinterface

// File: rtl/dual_port_ram_be_clear_seq.sv
// Clear sequencer: after reset walks a pointer over every word, issuing a
// zero-write per cycle, then parks in READY.
//   clk, rst_n : clock, synchronous active-low reset
//   clr_we     : clear write strobe (overrides the user write port)
//   clr_addr   : word being cleared
//   init_done  : high in READY
module ram_clear_seq
   import dual_port_ram_be_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH     = 7,
   parameter bit          CLEAR_ON_RESET = 1'b1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   output logic                  clr_we,
   output logic [ADDR_WIDTH-1:0] clr_addr,
   output logic                  init_done
);

   ram_state_e            state;
   ram_state_e            state_nxt;
   logic [ADDR_WIDTH-1:0] ptr;
   logic                  clr_active;

   assign clr_active = (state == ST_CLEAR) && CLEAR_ON_RESET;

   always_ff @(posedge clk) begin
      if (!rst_n) state <= ST_CLEAR;
      else        state <= state_nxt;
   end

   always_ff @(posedge clk) begin
      if (!rst_n)          ptr <= '0;
      else if (clr_active) ptr <= ptr + 1'b1;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_CLEAR: if (!CLEAR_ON_RESET || (ptr == '1)) state_nxt = ST_READY;
         ST_READY: state_nxt = ST_READY;
         default:  state_nxt = ST_CLEAR;
      endcase
   end

   // rst_n gate keeps the array untouched while reset is held.
   always_comb begin
      clr_we    = clr_active && rst_n;
      clr_addr  = ptr;
      init_done = (state == ST_READY);
   end

endmodule

// File: rtl/dual_port_ram_be.sv
// Simple dual-port RAM (one write port, one read port) with byte enables,
// optional registered read with selectable read-during-write behaviour, and
// optional zero-fill of the whole array after reset.
//   clk, rst_n : clock, synchronous active-low reset
//   bus        : dual_port_ram_be_if slave (write port, read port, init_done)
module dual_port_ram_be
   import dual_port_ram_be_pkg::*;
#(
   parameter int unsigned DATA_WIDTH     = 32,
   parameter int unsigned ADDR_WIDTH     = 7,
   parameter bit          REG_OUT        = 1'b1,
   parameter rdw_mode_e   RDW_MODE       = RDW_WRITE_FIRST,
   parameter bit          CLEAR_ON_RESET = 1'b1
) (
   input logic               clk,
   input logic               rst_n,
   dual_port_ram_be_if.slave bus
);

   localparam int unsigned DEPTH     = 1 << ADDR_WIDTH;
   localparam int unsigned NUM_BYTES = DATA_WIDTH / 8;

   if (DATA_WIDTH % 8 != 0) begin : g_width_check
      $error("dual_port_ram_be: DATA_WIDTH must be a multiple of 8");
   end

   logic [DATA_WIDTH-1:0] mem [DEPTH];

   logic                  clr_we;
   logic [ADDR_WIDTH-1:0] clr_addr;
   logic                  init_done;
   logic                  user_we;
   logic                  rd_fire;
   logic [DATA_WIDTH-1:0] old_word;
   logic [DATA_WIDTH-1:0] merged;
   logic [DATA_WIDTH-1:0] rd_data_r;
   logic                  rd_valid_r;

   ram_clear_seq #(
      .ADDR_WIDTH     (ADDR_WIDTH),
      .CLEAR_ON_RESET (CLEAR_ON_RESET)
   ) u_clear_seq (
      .clk       (clk),
      .rst_n     (rst_n),
      .clr_we    (clr_we),
      .clr_addr  (clr_addr),
      .init_done (init_done)
   );

   assign user_we = init_done && bus.wr_en;
   assign rd_fire = init_done && bus.rd_en;

   // Read-modify-write word; also the write-first bypass value.
   always_comb begin
      old_word = mem[bus.wr_addr];
      merged   = old_word;
      for (int unsigned i = 0; i < NUM_BYTES; i++) begin
         merged[8*i +: 8] = byte_merge(old_word[8*i +: 8], bus.wr_data[8*i +: 8], bus.wr_be[i]);
      end
   end

   always_ff @(posedge clk) begin
      if (clr_we)       mem[clr_addr]    <= '0;
      else if (user_we) mem[bus.wr_addr] <= merged;
   end

   if (REG_OUT) begin : g_reg_rd
      logic bypass;
      assign bypass = (RDW_MODE == RDW_WRITE_FIRST) && user_we && (bus.wr_addr == bus.rd_addr);

      // Array read sees the pre-edge word, so READ_FIRST needs no extra logic.
      always_ff @(posedge clk) begin
         if (!rst_n) begin
            rd_data_r  <= '0;
            rd_valid_r <= 1'b0;
         end else begin
            rd_valid_r <= rd_fire;
            if (rd_fire) rd_data_r <= bypass ? merged : mem[bus.rd_addr];
         end
      end
   end else begin : g_comb_rd
      always_comb begin
         rd_data_r  = mem[bus.rd_addr];
         rd_valid_r = rd_fire;
      end
   end

   assign bus.rd_data   = rd_data_r;
   assign bus.rd_valid  = rd_valid_r;
   assign bus.init_done = init_done;

endmodule

// File: tb/tb_dual_port_ram_be.sv
// Directed and randomised checks of dual_port_ram_be in four configurations:
// registered write-first, registered read-first, combinational read, and
// registered without clear-on-reset.
module tb_dual_port_ram_be;
   import dual_port_ram_be_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        wr_en;
   logic [3:0]  wr_addr;
   logic [31:0] wr_data;
   logic [3:0]  wr_be;
   logic        rd_en;
   logic [3:0]  rd_addr;

   int n_checks = 0;
   int n_fail   = 0;

   logic [31:0] mem_m [16];
   logic [31:0] exp_wf;
   logic [31:0] exp_rf;

   always #5 clk = ~clk;

   dual_port_ram_be_if #(.DATA_WIDTH(32), .ADDR_WIDTH(4)) if_wf ();
   dual_port_ram_be_if #(.DATA_WIDTH(32), .ADDR_WIDTH(4)) if_rf ();
   dual_port_ram_be_if #(.DATA_WIDTH(32), .ADDR_WIDTH(4)) if_cb ();
   dual_port_ram_be_if #(.DATA_WIDTH(32), .ADDR_WIDTH(4)) if_nc ();

   assign if_wf.wr_en = wr_en;   assign if_rf.wr_en = wr_en;
   assign if_cb.wr_en = wr_en;   assign if_nc.wr_en = wr_en;
   assign if_wf.wr_addr = wr_addr; assign if_rf.wr_addr = wr_addr;
   assign if_cb.wr_addr = wr_addr; assign if_nc.wr_addr = wr_addr;
   assign if_wf.wr_data = wr_data; assign if_rf.wr_data = wr_data;
   assign if_cb.wr_data = wr_data; assign if_nc.wr_data = wr_data;
   assign if_wf.wr_be = wr_be;   assign if_rf.wr_be = wr_be;
   assign if_cb.wr_be = wr_be;   assign if_nc.wr_be = wr_be;
   assign if_wf.rd_en = rd_en;   assign if_rf.rd_en = rd_en;
   assign if_cb.rd_en = rd_en;   assign if_nc.rd_en = rd_en;
   assign if_wf.rd_addr = rd_addr; assign if_rf.rd_addr = rd_addr;
   assign if_cb.rd_addr = rd_addr; assign if_nc.rd_addr = rd_addr;

   dual_port_ram_be #(.DATA_WIDTH(32), .ADDR_WIDTH(4), .REG_OUT(1'b1),
                      .RDW_MODE(RDW_WRITE_FIRST), .CLEAR_ON_RESET(1'b1))
      dut_wf (.clk(clk), .rst_n(rst_n), .bus(if_wf));
   dual_port_ram_be #(.DATA_WIDTH(32), .ADDR_WIDTH(4), .REG_OUT(1'b1),
                      .RDW_MODE(RDW_READ_FIRST), .CLEAR_ON_RESET(1'b1))
      dut_rf (.clk(clk), .rst_n(rst_n), .bus(if_rf));
   dual_port_ram_be #(.DATA_WIDTH(32), .ADDR_WIDTH(4), .REG_OUT(1'b0),
                      .RDW_MODE(RDW_WRITE_FIRST), .CLEAR_ON_RESET(1'b1))
      dut_cb (.clk(clk), .rst_n(rst_n), .bus(if_cb));
   dual_port_ram_be #(.DATA_WIDTH(32), .ADDR_WIDTH(4), .REG_OUT(1'b1),
                      .RDW_MODE(RDW_WRITE_FIRST), .CLEAR_ON_RESET(1'b0))
      dut_nc (.clk(clk), .rst_n(rst_n), .bus(if_nc));

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] model_merge(input logic [31:0] old_w,
                                               input logic [31:0] new_w,
                                               input logic [3:0]  be);
      logic [31:0] mask;
      for (int i = 0; i < 4; i++) mask[8*i +: 8] = {8{be[i]}};
      return (old_w & ~mask) | (new_w & mask);
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      wr_en = 1'b0; wr_addr = '0; wr_data = '0; wr_be = '0;
      rd_en = 1'b0; rd_addr = '0;
   endtask

   task automatic model_clear();
      for (int i = 0; i < 16; i++) mem_m[i] = '0;
   endtask

   task automatic do_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] be);
      wr_en = 1'b1; wr_addr = a; wr_data = d; wr_be = be;
      tick();
      wr_en = 1'b0;
      mem_m[a] = model_merge(mem_m[a], d, be);
   endtask

   // Read one address on all three cleared DUTs; exp is a hand-computed value.
   task automatic do_read(input string tag, input logic [3:0] a, input logic [31:0] exp);
      rd_en = 1'b1; rd_addr = a;
      #1;
      check_eq({tag, "_cb_data"}, if_cb.rd_data, exp);
      check_eq({tag, "_cb_valid"}, {31'b0, if_cb.rd_valid}, 32'd1);
      tick();
      rd_en = 1'b0;
      check_eq({tag, "_wf_data"}, if_wf.rd_data, exp);
      check_eq({tag, "_rf_data"}, if_rf.rd_data, exp);
      check_eq({tag, "_wf_valid"}, {31'b0, if_wf.rd_valid}, 32'd1);
      exp_wf = exp;
      exp_rf = exp;
   endtask

   initial begin
      logic [31:0] new_w;
      idle();
      rst_n = 1'b0;
      repeat (3) tick();

      // Reset state
      check_eq("rst_wf_data", if_wf.rd_data, 32'h0);
      check_eq("rst_wf_valid", {31'b0, if_wf.rd_valid}, 32'd0);
      check_eq("rst_wf_init", {31'b0, if_wf.init_done}, 32'd0);
      check_eq("rst_nc_init", {31'b0, if_nc.init_done}, 32'd0);

      // Clear: init_done rises after exactly 16 cycles; no-clear variant after 1
      rst_n = 1'b1;
      for (int k = 1; k <= 16; k++) begin
         tick();
         check_eq("clr_init_done", {31'b0, if_wf.init_done}, (k == 16) ? 32'd1 : 32'd0);
         if (k == 1) check_eq("nc_init_done", {31'b0, if_nc.init_done}, 32'd1);
      end
      model_clear();
      for (int a = 0; a < 16; a++) do_read("clr_read", 4'(a), 32'h0);

      // Byte enables
      do_write(4'd5, 32'hAABBCCDD, 4'hF);
      do_write(4'd5, 32'h11223344, 4'b0101);
      do_read("be_merge", 4'd5, 32'hAA22CC44);
      do_write(4'd5, 32'hDEADBEEF, 4'b0000);
      do_read("be_zero", 4'd5, 32'hAA22CC44);

      // Latency
      do_write(4'd3, 32'h12345678, 4'hF);
      rd_en = 1'b1; rd_addr = 4'd3;
      #1;
      check_eq("lat_cb_same_cycle", if_cb.rd_data, 32'h12345678);
      check_eq("lat_wf_valid_pre", {31'b0, if_wf.rd_valid}, 32'd0);
      tick();
      rd_en = 1'b0;
      check_eq("lat_wf_data", if_wf.rd_data, 32'h12345678);
      check_eq("lat_wf_valid", {31'b0, if_wf.rd_valid}, 32'd1);
      tick();
      check_eq("hold_wf_valid", {31'b0, if_wf.rd_valid}, 32'd0);
      check_eq("hold_wf_data", if_wf.rd_data, 32'h12345678);

      // Combinational read: same-cycle write visible only after the edge
      wr_en = 1'b1; wr_addr = 4'd7; wr_data = 32'hCAFEF00D; wr_be = 4'hF;
      rd_en = 1'b1; rd_addr = 4'd7;
      #1;
      check_eq("cb_rdw_pre", if_cb.rd_data, 32'h0);
      tick();
      wr_en = 1'b0; rd_en = 1'b0;
      #1;
      check_eq("cb_rdw_post", if_cb.rd_data, 32'hCAFEF00D);
      mem_m[7] = 32'hCAFEF00D;

      // Read-during-write on word 9 (still zero)
      wr_en = 1'b1; wr_addr = 4'd9; wr_data = 32'hFFFFFFFF; wr_be = 4'b0011;
      rd_en = 1'b1; rd_addr = 4'd9;
      tick();
      idle();
      check_eq("rdw_write_first", if_wf.rd_data, 32'h0000FFFF);
      check_eq("rdw_read_first", if_rf.rd_data, 32'h00000000);
      mem_m[9] = 32'h0000FFFF;
      do_read("rdw_after", 4'd9, 32'h0000FFFF);

      // Reset mid-clear restarts the full sweep; writes/reads during clear ignored
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      repeat (7) tick();
      rst_n = 1'b0;
      tick();
      check_eq("midclr_rst_init", {31'b0, if_wf.init_done}, 32'd0);
      check_eq("midclr_rst_valid", {31'b0, if_wf.rd_valid}, 32'd0);
      rst_n = 1'b1;
      for (int k = 1; k <= 16; k++) begin
         if (k == 12) begin
            wr_en = 1'b1; wr_addr = 4'd3; wr_data = 32'h5A5A5A5A; wr_be = 4'hF;
         end else begin
            wr_en = 1'b0;
         end
         rd_en = 1'b1; rd_addr = 4'd3;
         tick();
         check_eq("midclr_init_done", {31'b0, if_wf.init_done}, (k == 16) ? 32'd1 : 32'd0);
         check_eq("midclr_rd_valid", {31'b0, if_wf.rd_valid}, 32'd0);
      end
      idle();
      model_clear();
      do_read("midclr_wr_ignored", 4'd3, 32'h0);
      do_read("midclr_cleared", 4'd5, 32'h0);

      // Random dual-port traffic against the reference model
      for (int c = 0; c < 10000; c++) begin
         wr_en   = 1'($urandom_range(0, 1));
         wr_addr = 4'($urandom_range(0, 15));
         wr_data = $urandom;
         wr_be   = 4'($urandom_range(0, 15));
         rd_en   = 1'($urandom_range(0, 1));
         rd_addr = ($urandom_range(0, 3) == 0) ? wr_addr : 4'($urandom_range(0, 15));
         #1;
         check_eq("rnd_cb_valid", {31'b0, if_cb.rd_valid}, {31'b0, rd_en});
         if (rd_en) check_eq("rnd_cb_data", if_cb.rd_data, mem_m[rd_addr]);
         new_w = model_merge(mem_m[wr_addr], wr_data, wr_be);
         if (rd_en) begin
            exp_rf = mem_m[rd_addr];
            exp_wf = (wr_en && (wr_addr == rd_addr)) ? new_w : mem_m[rd_addr];
         end
         if (wr_en) mem_m[wr_addr] = new_w;
         tick();
         check_eq("rnd_wf_valid", {31'b0, if_wf.rd_valid}, {31'b0, rd_en});
         check_eq("rnd_rf_valid", {31'b0, if_rf.rd_valid}, {31'b0, rd_en});
         check_eq("rnd_wf_data", if_wf.rd_data, exp_wf);
         check_eq("rnd_rf_data", if_rf.rd_data, exp_rf);
      end
      idle();
      tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
